// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CR16-subset control unit: FSM states, instruction
// classes, opcode/opext constants and small decode helpers.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_LOAD_WB = 3'd3
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP   = 3'd0,
        CL_ALU_R = 3'd1,
        CL_ALU_I = 3'd2,
        CL_LOAD  = 3'd3,
        CL_STOR  = 3'd4
    } iclass_t;

    // IR[15:12] major opcodes
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // IR[7:4] extended opcodes
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    // Shared ALU codes; the same values appear as ext (reg-reg) and opcode (imm).
    function automatic logic is_alu_code(input logic [3:0] code);
        case (code)
            EXT_AND, EXT_OR, EXT_XOR, EXT_ADD,
            EXT_SUB, EXT_CMP, EXT_MOV: is_alu_code = 1'b1;
            default:                   is_alu_code = 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] wr_enable(input logic [3:0]  addr,
                                              input logic [15:0] mask);
        wr_enable = (16'h0001 << addr) & ~mask;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_instr_decode.sv
// Pure combinational classification of the latched instruction fields.
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [3:0] i_ext,
    output iclass_t    o_class,
    output logic [3:0] o_alu_op,
    output logic       o_writes_reg,
    output logic       o_use_imm
);

    always_comb begin
        o_class      = CL_NOP;
        o_alu_op     = 4'd0;
        o_writes_reg = 1'b0;
        o_use_imm    = 1'b0;

        if (i_opcode == OP_RTYPE) begin
            if (is_alu_code(i_ext)) begin
                o_class      = CL_ALU_R;
                o_alu_op     = i_ext;
                o_writes_reg = (i_ext != EXT_CMP);
            end
        end else if (i_opcode == OP_MEM) begin
            if (i_ext == EXT_LOAD) begin
                o_class      = CL_LOAD;
                o_writes_reg = 1'b1;
            end else if (i_ext == EXT_STOR) begin
                o_class = CL_STOR;
            end
        end else if (is_alu_code(i_opcode) || (i_opcode == OP_LUI)) begin
            // LUI only exists in immediate form
            o_class      = CL_ALU_I;
            o_alu_op     = i_opcode;
            o_use_imm    = 1'b1;
            o_writes_reg = (i_opcode != OP_CMPI);
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/LOAD_WB sequencer; outputs are combinational
// from the current state and the instruction register.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter logic [15:0] PROTECT_MASK = 16'h2000,
    parameter logic [15:0] IR_RESET     = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] mem_rdata,
    output logic [15:0] reg_en,
    output logic [3:0]  raddr_a,
    output logic [3:0]  raddr_b,
    output logic [3:0]  alu_op,
    output logic        use_imm,
    output logic [7:0]  imm,
    output logic        flags_en,
    output logic        pc_en,
    output logic        addr_sel,
    output logic        wb_sel,
    output logic        mem_we,
    output logic [2:0]  state_dbg
);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;

    iclass_t     w_class;
    logic [3:0]  w_alu_op;
    logic        w_writes_reg;
    logic        w_use_imm;
    logic [15:0] w_wr_en;

    instr_decode u_decode (
        .i_opcode     (r_ir[15:12]),
        .i_ext        (r_ir[7:4]),
        .o_class      (w_class),
        .o_alu_op     (w_alu_op),
        .o_writes_reg (w_writes_reg),
        .o_use_imm    (w_use_imm)
    );

    assign w_wr_en   = wr_enable(r_ir[11:8], PROTECT_MASK);
    assign raddr_a   = r_ir[11:8];
    assign raddr_b   = r_ir[3:0];
    assign imm       = r_ir[7:0];
    assign state_dbg = r_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH;
            r_ir    <= IR_RESET;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_DECODE) begin
                r_ir <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        reg_en       = 16'h0000;
        alu_op       = 4'd0;
        use_imm      = 1'b0;
        flags_en     = 1'b0;
        pc_en        = 1'b0;
        addr_sel     = 1'b0;
        wb_sel       = 1'b0;
        mem_we       = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_next_state = run ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                pc_en        = 1'b1;
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_next_state = ST_FETCH;
                case (w_class)
                    CL_ALU_R, CL_ALU_I: begin
                        alu_op   = w_alu_op;
                        use_imm  = w_use_imm;
                        flags_en = 1'b1;
                        if (w_writes_reg) begin
                            reg_en = w_wr_en;
                        end
                    end
                    CL_LOAD: begin
                        addr_sel     = 1'b1;
                        w_next_state = ST_LOAD_WB;
                    end
                    CL_STOR: begin
                        // data = rdataA, address = rdataB
                        addr_sel = 1'b1;
                        mem_we   = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            ST_LOAD_WB: begin
                wb_sel       = 1'b1;
                reg_en       = w_wr_en;
                w_next_state = ST_FETCH;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: instruction vector table plus a queue scoreboard
// compared whenever the FSM is in EXEC or LOAD_WB.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] mem_rdata;
    logic [15:0] reg_en;
    logic [3:0]  raddr_a, raddr_b, alu_op;
    logic        use_imm;
    logic [7:0]  imm;
    logic        flags_en, pc_en, addr_sel, wb_sel, mem_we;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    cpu_ctrl_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_rdata (mem_rdata),
        .reg_en    (reg_en),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .alu_op    (alu_op),
        .use_imm   (use_imm),
        .imm       (imm),
        .flags_en  (flags_en),
        .pc_en     (pc_en),
        .addr_sel  (addr_sel),
        .wb_sel    (wb_sel),
        .mem_we    (mem_we),
        .state_dbg (state_dbg)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] reg_en;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  alu_op;
        logic        use_imm;
        logic [7:0]  imm;
        logic        flags_en;
        logic        pc_en;
        logic        addr_sel;
        logic        wb_sel;
        logic        mem_we;
    } out_t;

    typedef struct {
        logic [15:0] ir;
        out_t        ex;
        logic        is_load;
        out_t        wb;
    } vec_t;

    out_t act;
    assign act = {state_dbg, reg_en, raddr_a, raddr_b, alu_op, use_imm, imm,
                  flags_en, pc_en, addr_sel, wb_sel, mem_we};

    out_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[14];

    function automatic out_t exp_o(input logic [15:0] ir, input logic [2:0] st,
                                   input logic [15:0] ren, input logic [3:0] op,
                                   input logic ui, input logic fe, input logic as,
                                   input logic wbs, input logic we);
        out_t o;
        o.st       = st;
        o.reg_en   = ren;
        o.ra       = ir[11:8];
        o.rb       = ir[3:0];
        o.alu_op   = op;
        o.use_imm  = ui;
        o.imm      = ir[7:0];
        o.flags_en = fe;
        o.pc_en    = 1'b0;
        o.addr_sel = as;
        o.wb_sel   = wbs;
        o.mem_we   = we;
        return o;
    endfunction

    task automatic check_out(input string name, input out_t got, input out_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got st=%0d reg_en=%h ra=%h rb=%h op=%h ui=%b imm=%h fe=%b pc=%b as=%b wb=%b we=%b, want st=%0d reg_en=%h ra=%h rb=%h op=%h ui=%b imm=%h fe=%b pc=%b as=%b wb=%b we=%b",
                     name, got.st, got.reg_en, got.ra, got.rb, got.alu_op, got.use_imm, got.imm,
                     got.flags_en, got.pc_en, got.addr_sel, got.wb_sel, got.mem_we,
                     want.st, want.reg_en, want.ra, want.rb, want.alu_op, want.use_imm, want.imm,
                     want.flags_en, want.pc_en, want.addr_sel, want.wb_sel, want.mem_we);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Scoreboard consumer and structural invariants
    always @(negedge clk) begin : monitor
        out_t e;
        if (state_dbg == 3'd2 || state_dbg == 3'd3) begin
            if (q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: state %0d reached with no expected entry", state_dbg);
            end else begin
                e = q_exp.pop_front();
                check_out("sb_out", act, e);
            end
        end
        if (reset === 1'b1) begin
            n_tests++;
            if (!$onehot0(reg_en) || (reg_en & 16'h2000) != 16'h0 ||
                (mem_we && reg_en != 16'h0) || (pc_en && state_dbg != 3'd1)) begin
                n_fail++;
                $display("FAIL invariant: state=%0d reg_en=%h mem_we=%b pc_en=%b",
                         state_dbg, reg_en, mem_we, pc_en);
            end
        end
    end

    // Starts and ends at #1 after an edge with the FSM in FETCH and run=1.
    task automatic do_instr(input vec_t v, input logic drop_run);
        @(posedge clk); #1;
        check_val("decode_state", 32'(state_dbg), 32'd1);
        check_val("decode_pc_en", 32'(pc_en), 32'd1);
        check_val("decode_enables", 32'({reg_en, flags_en, mem_we, addr_sel, wb_sel}), 32'd0);
        mem_rdata = v.ir;
        q_exp.push_back(v.ex);
        if (v.is_load) q_exp.push_back(v.wb);
        if (drop_run) run = 1'b0;
        @(posedge clk); #1;
        mem_rdata = 16'($urandom);
        if (v.is_load) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check_val("back_to_fetch", 32'(state_dbg), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{16'h0351, exp_o(16'h0351, 3'd2, 16'h0008, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, '0};
        vecs[1]  = '{16'h5D07, exp_o(16'h5D07, 3'd2, 16'h0000, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, '0};
        vecs[2]  = '{16'h4204, exp_o(16'h4204, 3'd2, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1,
                     exp_o(16'h4204, 3'd3, 16'h0004, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
        vecs[3]  = '{16'h4644, exp_o(16'h4644, 3'd2, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0, '0};
        vecs[4]  = '{16'h0BB2, exp_o(16'h0BB2, 3'd2, 16'h0000, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, '0};
        vecs[5]  = '{16'h7000, exp_o(16'h7000, 3'd2, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, '0};
        vecs[6]  = '{16'h0FD1, exp_o(16'h0FD1, 3'd2, 16'h8000, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, '0};
        vecs[7]  = '{16'hF5AB, exp_o(16'hF5AB, 3'd2, 16'h0020, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, '0};
        vecs[8]  = '{16'h03F1, exp_o(16'h03F1, 3'd2, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, '0};
        vecs[9]  = '{16'hB123, exp_o(16'hB123, 3'd2, 16'h0000, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, '0};
        vecs[10] = '{16'h4381, exp_o(16'h4381, 3'd2, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, '0};
        vecs[11] = '{16'h4D04, exp_o(16'h4D04, 3'd2, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1,
                     exp_o(16'h4D04, 3'd3, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
        vecs[12] = '{16'h9005, exp_o(16'h9005, 3'd2, 16'h0001, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, '0};
        vecs[13] = '{16'h3A0F, exp_o(16'h3A0F, 3'd2, 16'h0400, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, '0};

        reset     = 1'b0;
        run       = 1'b0;
        mem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", act, exp_o(16'h0000, 3'd0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("hold_run0", 32'(state_dbg), 32'd0);
        end

        run = 1'b1;
        for (int i = 0; i < 14; i++) begin
            do_instr(vecs[i], 1'b0);
        end

        // Dropping run in DECODE still completes the instruction, then halts.
        do_instr(vecs[0], 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_val("halt_after_drop", 32'(state_dbg), 32'd0);
        end

        // Reset while in LOAD_WB discards the writeback.
        run = 1'b1;
        @(posedge clk); #1;
        mem_rdata = 16'h4204;
        q_exp.push_back(vecs[2].ex);
        q_exp.push_back(vecs[2].wb);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("in_load_wb", 32'(state_dbg), 32'd3);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("rst_wb_state", 32'(state_dbg), 32'd0);
        check_val("rst_wb_reg_en", 32'(reg_en), 32'd0);
        check_val("rst_wb_ir", 32'({raddr_a, raddr_b, imm}), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("resume_decode", 32'(state_dbg), 32'd1);
        mem_rdata = 16'h0351;
        q_exp.push_back(vecs[0].ex);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("resume_fetch", 32'(state_dbg), 32'd0);

        run = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending entries want 0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
